// File: rtl/data_line_ctrl.sv
// Data-line sequencer: owns the cell address and strobes the data counter so it mirrors RAM.
// Build option DATA_LINE_CTRL_LAZY_STORE_EN selects lazy write-back; undefined gives write-through.
module data_line_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned MAX_ADDRESS   = 29999
) (
    input  logic                     CLOCK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    input  logic [2:0]               CMD,
    output logic                     CMD_READY,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    output logic                     LOAD,
    output logic                     STORE,
    output logic                     INC,
    output logic                     DEC,
    output logic                     LOADED,
    output logic                     DIRTY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_MOVE  = 2'd3;

    localparam logic [2:0] C_DINC  = 3'b001;
    localparam logic [2:0] C_DDEC  = 3'b010;
    localparam logic [2:0] C_AINC  = 3'b011;
    localparam logic [2:0] C_ADEC  = 3'b100;
    localparam logic [2:0] C_FLUSH = 3'b101;
    localparam logic [2:0] C_INVAL = 3'b110;

    localparam logic [ADDRESS_WIDTH-1:0] MAX_A = ADDRESS_WIDTH'(MAX_ADDRESS);

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     load_q, load_d;
    logic                     store_q, store_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     loaded_q, loaded_d;
    logic                     dirty_q, dirty_d;
    logic                     dec_op_q, dec_op_d;
    logic                     accept;

    function automatic logic [ADDRESS_WIDTH-1:0] step_addr(
        input logic [ADDRESS_WIDTH-1:0] a,
        input logic                     down
    );
        if (down) begin
            step_addr = (a == '0) ? MAX_A : a - 1'b1;
        end else begin
            step_addr = (a >= MAX_A) ? '0 : a + 1'b1;
        end
    endfunction

`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
    // Pending address move carried through the STORE state of a dirty AINC/ADEC.
    logic mv_q, mv_d;
    logic mv_down_q, mv_down_d;

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            mv_q      <= 1'b0;
            mv_down_q <= 1'b0;
        end else begin
            mv_q      <= mv_d;
            mv_down_q <= mv_down_d;
        end
    end
`endif

    assign accept = CMD_VALID && (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        load_d   = 1'b0;
        store_d  = 1'b0;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        loaded_d = loaded_q;
        dirty_d  = dirty_q;
        dec_op_d = dec_op_q;
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
        mv_d      = mv_q;
        mv_down_d = mv_down_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (CMD)
                        C_DINC, C_DDEC: begin
                            dec_op_d = (CMD == C_DDEC);
                            if (loaded_q) begin
                                inc_d = (CMD == C_DINC);
                                dec_d = (CMD == C_DDEC);
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
                                dirty_d = 1'b1;
`else
                                state_d = S_STORE;
`endif
                            end else begin
                                load_d  = 1'b1;
                                state_d = S_LOAD;
                            end
                        end
                        C_AINC, C_ADEC: begin
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
                            if (dirty_q) begin
                                store_d   = 1'b1;
                                mv_d      = 1'b1;
                                mv_down_d = (CMD == C_ADEC);
                                state_d   = S_STORE;
                            end else begin
                                addr_d   = step_addr(addr_q, CMD == C_ADEC);
                                loaded_d = 1'b0;
                            end
`else
                            addr_d   = step_addr(addr_q, CMD == C_ADEC);
                            loaded_d = 1'b0;
`endif
                        end
                        C_FLUSH: begin
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
                            if (dirty_q) begin
                                store_d = 1'b1;
                                mv_d    = 1'b0;
                                state_d = S_STORE;
                            end
`endif
                        end
                        C_INVAL: begin
                            loaded_d = 1'b0;
                            dirty_d  = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_LOAD: begin
                inc_d    = !dec_op_q;
                dec_d    = dec_op_q;
                loaded_d = 1'b1;
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
                dirty_d = 1'b1;
                state_d = S_IDLE;
`else
                state_d = S_STORE;
`endif
            end
            S_STORE: begin
                // Lazy: STORE strobe is already out; write-through: INC/DEC is out, store follows.
`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
                dirty_d = 1'b0;
                if (mv_q) begin
                    addr_d   = step_addr(addr_q, mv_down_q);
                    loaded_d = 1'b0;
                    state_d  = S_MOVE;
                end else begin
                    state_d = S_IDLE;
                end
`else
                store_d = 1'b1;
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            loaded_q <= 1'b0;
            dirty_q  <= 1'b0;
            dec_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            load_q   <= load_d;
            store_q  <= store_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            loaded_q <= loaded_d;
            dirty_q  <= dirty_d;
            dec_op_q <= dec_op_d;
        end
    end

    assign CMD_READY = (state_q == S_IDLE);
    assign ADDRESS   = addr_q;
    assign LOAD      = load_q;
    assign STORE     = store_q;
    assign INC       = inc_q;
    assign DEC       = dec_q;
    assign LOADED    = loaded_q;
    assign DIRTY     = dirty_q;

endmodule

// File: tb/tb_data_line_ctrl.sv
// Directed bench for data_line_ctrl; expectations follow whichever store mode
// DATA_LINE_CTRL_LAZY_STORE_EN selects at compile time.
module tb_data_line_ctrl;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] DINC  = 3'b001;
    localparam logic [2:0] DDEC  = 3'b010;
    localparam logic [2:0] AINC  = 3'b011;
    localparam logic [2:0] ADEC  = 3'b100;
    localparam logic [2:0] FLUSH = 3'b101;
    localparam logic [2:0] INVAL = 3'b110;

    localparam logic [3:0] S_NONE  = 4'b0000;
    localparam logic [3:0] S_LOAD  = 4'b1000;
    localparam logic [3:0] S_STORE = 4'b0100;
    localparam logic [3:0] S_INC   = 4'b0010;
    localparam logic [3:0] S_DEC   = 4'b0001;

    logic        CLOCK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic [2:0]  CMD = NOP;
    logic        CMD_READY;
    logic [15:0] ADDRESS;
    logic        LOAD, STORE, INC, DEC, LOADED, DIRTY;

    int n_checks = 0;
    int n_errors = 0;

    data_line_ctrl #(.ADDRESS_WIDTH(16), .MAX_ADDRESS(29999)) dut (
        .CLOCK    (CLOCK),
        .RST      (RST),
        .CMD_VALID(CMD_VALID),
        .CMD      (CMD),
        .CMD_READY(CMD_READY),
        .ADDRESS  (ADDRESS),
        .LOAD     (LOAD),
        .STORE    (STORE),
        .INC      (INC),
        .DEC      (DEC),
        .LOADED   (LOADED),
        .DIRTY    (DIRTY)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] stb, input int addr,
                              input logic ld, input logic dt, input logic rdy);
        check({tag, ".strobes"}, {28'd0, LOAD, STORE, INC, DEC}, {28'd0, stb});
        check({tag, ".address"}, {16'd0, ADDRESS}, addr);
        check({tag, ".loaded"}, {31'd0, LOADED}, {31'd0, ld});
        check({tag, ".dirty"}, {31'd0, DIRTY}, {31'd0, dt});
        check({tag, ".ready"}, {31'd0, CMD_READY}, {31'd0, rdy});
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Waits (bounded) for READY, presents the command over one accept edge.
    task automatic send(input logic [2:0] c);
        int unsigned n;
        n = 0;
        while (!CMD_READY && n < 20) begin
            step();
            n++;
        end
        check("ready_before_send", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD = c;
        @(posedge CLOCK);
        #1;
        CMD_VALID = 1'b0;
        CMD = NOP;
    endtask

    initial begin
        repeat (2) @(posedge CLOCK);
        #1;
        expect_out("reset", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        RST = 1'b0;
        step();
        expect_out("post_reset", S_NONE, 0, 1'b0, 1'b0, 1'b1);

`ifdef DATA_LINE_CTRL_LAZY_STORE_EN
        send(DINC);
        expect_out("dinc1_load", S_LOAD, 0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("dinc1_inc", S_INC, 0, 1'b1, 1'b1, 1'b1);
        send(DINC);
        expect_out("dinc2_inc", S_INC, 0, 1'b1, 1'b1, 1'b1);
        send(DINC);
        expect_out("dinc3_inc", S_INC, 0, 1'b1, 1'b1, 1'b1);
        step();
        expect_out("dinc_idle", S_NONE, 0, 1'b1, 1'b1, 1'b1);

        send(INVAL);
        expect_out("inval", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            send(AINC);
            expect_out("ainc_clean", S_NONE, i, 1'b0, 1'b0, 1'b1);
        end

        send(DINC);
        expect_out("a5_load", S_LOAD, 5, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("a5_inc", S_INC, 5, 1'b1, 1'b1, 1'b1);
        send(AINC);
        expect_out("dirty_ainc_store", S_STORE, 5, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("dirty_ainc_move", S_NONE, 6, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("dirty_ainc_done", S_NONE, 6, 1'b0, 1'b0, 1'b1);

        for (int i = 5; i >= 0; i--) begin
            send(ADEC);
            expect_out("adec_clean", S_NONE, i, 1'b0, 1'b0, 1'b1);
        end
        send(ADEC);
        expect_out("adec_wrap", S_NONE, 29999, 1'b0, 1'b0, 1'b1);
        send(AINC);
        expect_out("ainc_wrap", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        send(ADEC);
        expect_out("adec_wrap2", S_NONE, 29999, 1'b0, 1'b0, 1'b1);

        send(DINC);
        expect_out("top_load", S_LOAD, 29999, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("top_inc", S_INC, 29999, 1'b1, 1'b1, 1'b1);
        send(FLUSH);
        expect_out("flush_store", S_STORE, 29999, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("flush_done", S_NONE, 29999, 1'b1, 1'b0, 1'b1);
        send(FLUSH);
        expect_out("flush_clean", S_NONE, 29999, 1'b1, 1'b0, 1'b1);
        send(DDEC);
        expect_out("ddec_loaded", S_DEC, 29999, 1'b1, 1'b1, 1'b1);
        send(3'b111);
        expect_out("reserved_nop", S_NONE, 29999, 1'b1, 1'b1, 1'b1);

        send(AINC);
        expect_out("pre_rst_store", S_STORE, 29999, 1'b1, 1'b1, 1'b0);
`else
        send(DINC);
        expect_out("wt_load", S_LOAD, 0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("wt_load_inc", S_INC, 0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wt_load_store", S_STORE, 0, 1'b1, 1'b0, 1'b1);
        send(DINC);
        expect_out("wt_inc", S_INC, 0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wt_inc_store", S_STORE, 0, 1'b1, 1'b0, 1'b1);
        send(DDEC);
        expect_out("wt_dec", S_DEC, 0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wt_dec_store", S_STORE, 0, 1'b1, 1'b0, 1'b1);

        send(AINC);
        expect_out("wt_ainc", S_NONE, 1, 1'b0, 1'b0, 1'b1);
        send(FLUSH);
        expect_out("wt_flush", S_NONE, 1, 1'b0, 1'b0, 1'b1);
        send(ADEC);
        expect_out("wt_adec", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        send(ADEC);
        expect_out("wt_adec_wrap", S_NONE, 29999, 1'b0, 1'b0, 1'b1);
        send(AINC);
        expect_out("wt_ainc_wrap", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        send(ADEC);
        expect_out("wt_adec_wrap2", S_NONE, 29999, 1'b0, 1'b0, 1'b1);

        send(DINC);
        expect_out("wt_top_load", S_LOAD, 29999, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("wt_top_inc", S_INC, 29999, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("wt_top_store", S_STORE, 29999, 1'b1, 1'b0, 1'b1);
        send(INVAL);
        expect_out("wt_inval", S_NONE, 29999, 1'b0, 1'b0, 1'b1);

        send(DINC);
        expect_out("wt_rst_load", S_LOAD, 29999, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("pre_rst_inc", S_INC, 29999, 1'b1, 1'b0, 1'b0);
`endif

        RST = 1'b1;
        #1;
        expect_out("rst_mid_op", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        @(posedge CLOCK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("after_rst", S_NONE, 0, 1'b0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
